lsu_ctrl: RTL and testbench

- Parametrised load/store controller between the execute-stage control unit and data memory.
- Replaces the combinational load/store path with a handshaked multi-cycle FSM.
- Handles: effective-address generation, lane extraction with sign/zero extension, sub-word stores by read-modify-write or byte strobes, misalignment trapping.
- Supports XLEN 32 or 64; doubleword ops are legal only when XLEN=64.

---
 rtl/lsu_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_ctrl
// Load/store controller between the execute-stage control unit and data
// memory. A request is accepted in IDLE, its effective address is computed and
// checked for alignment/legality, and the access then runs as a handshaked
// multi-cycle sequence:
//   load            : RD_REQ -> RD_WAIT -> RESP
//   sub-word store  : RD_REQ -> RD_WAIT -> WR_REQ -> RESP   (RMW_STORE = 1)
//   strobed / full  : WR_REQ -> RESP
//   illegal request : RESP with resp_err = 1, no memory access
//
// Parameters
//   XLEN       datapath / address width, 32 or 64
//   RMW_STORE  1: sub-word stores read-merge-write a full word
//              0: sub-word stores are one write with byte strobes
//   NB         byte lanes per memory word (derived)
//
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   req_valid/req_ready            request handshake from the control unit
//   req_op                         {is_store, is_unsigned, size[1:0]}
//   req_base/req_offset/req_wdata  rs1, sign-extended immediate, rs2
//   resp_valid/resp_ready          response handshake
//   resp_data/resp_err             extended load data / misaligned or illegal
//   mem_req_valid/mem_req_ready    memory request handshake
//   mem_we/mem_addr/mem_wdata/mem_be  memory request fields (word aligned)
//   mem_rsp_valid/mem_rdata        read return
//   busy                           controller not idle
// ----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int       XLEN      = 32,
    parameter bit       RMW_STORE = 1'b1,
    localparam int      NB        = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_base,
    input  logic [XLEN-1:0] req_offset,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [NB-1:0]   mem_be,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    localparam int         LW     = $clog2(NB);
    localparam logic [7:0] XLEN_B = 8'(XLEN);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        RESP
    } state_t;

    state_t state_q, state_d;

    // Latched request
    logic            is_store_q;
    logic            is_unsigned_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] ea_q;
    logic [XLEN-1:0] wdata_q;
    logic            rmw_q;
    logic            err_q;
    // Holds the extended load result, or the merged word during an RMW store
    logic [XLEN-1:0] data_q;

    // ------------------------------------------------------------------
    // Request decode (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ea_in;
    logic            req_store;
    logic            req_unsigned;
    logic [1:0]      req_size;
    logic [2:0]      align_mask;
    logic            req_bad;
    logic            req_full;

    // NOTE: every variable driven here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_store    = req_op[3];
        req_unsigned = req_op[2];
        req_size     = req_op[1:0];
        ea_in        = req_base + req_offset;
        // size 3 wraps 3'd1 << 3 to zero, giving a mask of 3'b111
        align_mask   = (3'd1 << req_size) - 3'd1;
        req_bad      = (|(ea_in[2:0] & align_mask))
                     || ((XLEN == 32) && (req_size == 2'd3))
                     || (req_store && req_unsigned);
        req_full     = (req_size == 2'(LW));
    end

    // ------------------------------------------------------------------
    // Lane datapath: load extraction, RMW merge, strobe-mode write data
    // ------------------------------------------------------------------
    logic [LW-1:0]   lane_q;
    logic [1:0]      size_eff;
    int              nbytes;
    logic [7:0]      nbits;
    logic [7:0]      ext_sh;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] rd_top;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] wd_shift;
    logic [XLEN-1:0] merged;
    logic [XLEN-1:0] wdata_rep;
    logic [15:0]     be_wide;
    logic [NB-1:0]   be_lane;

    always_comb begin
        lane_q   = ea_q[LW-1:0];
        // A doubleword never reaches the datapath on XLEN=32 (it traps), the
        // clamp just keeps the shift amounts in range.
        size_eff = ((XLEN == 32) && (size_q == 2'd3)) ? 2'd2 : size_q;
        nbytes   = 1 << size_eff;
        nbits    = 8'd8 << size_eff;
        ext_sh   = XLEN_B - nbits;

        // Move the addressed field to the top, then shift back down either
        // logically or arithmetically to zero/sign extend it.
        rd_shift = mem_rdata >> {lane_q, 3'b000};
        rd_top   = rd_shift << ext_sh;
        load_ext = is_unsigned_q ? (rd_top >> ext_sh)
                                 : XLEN'($signed(rd_top) >>> ext_sh);

        be_wide  = 16'((1 << nbytes) - 1) << lane_q;
        be_lane  = be_wide[NB-1:0];

        wd_shift = wdata_q << {lane_q, 3'b000};
        for (int i = 0; i < NB; i++) begin
            merged[i*8 +: 8]    = be_lane[i] ? wd_shift[i*8 +: 8] : mem_rdata[i*8 +: 8];
            wdata_rep[i*8 +: 8] = wdata_q[(i % nbytes)*8 +: 8];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled at the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)                        state_d = RESP;
                    else if (!req_store)                state_d = RD_REQ;
                    else if (req_full || !RMW_STORE)    state_d = WR_REQ;
                    else                                state_d = RD_REQ;
                end
            end
            RD_REQ:  if (mem_req_ready) state_d = RD_WAIT;
            RD_WAIT: if (mem_rsp_valid) state_d = rmw_q ? WR_REQ : RESP;
            WR_REQ:  if (mem_req_ready) state_d = RESP;
            RESP:    if (resp_ready)    state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request / result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_store_q    <= 1'b0;
            is_unsigned_q <= 1'b0;
            size_q        <= 2'd0;
            ea_q          <= '0;
            wdata_q       <= '0;
            rmw_q         <= 1'b0;
            err_q         <= 1'b0;
            data_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q    <= req_store;
                        is_unsigned_q <= req_unsigned;
                        size_q        <= req_size;
                        ea_q          <= ea_in;
                        wdata_q       <= req_wdata;
                        rmw_q         <= req_store && !req_full && RMW_STORE && !req_bad;
                        err_q         <= req_bad;
                        data_q        <= '0;
                    end
                end
                RD_WAIT: begin
                    if (mem_rsp_valid) begin
                        data_q <= rmw_q ? merged : load_ext;
                    end
                end
                WR_REQ: begin
                    // Stores respond with zero data
                    if (mem_req_ready) begin
                        data_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from state and registered fields only
    // ------------------------------------------------------------------
    always_comb begin
        req_ready     = (state_q == IDLE);
        busy          = (state_q != IDLE);
        resp_valid    = (state_q == RESP);
        resp_err      = (state_q == RESP) && err_q;
        resp_data     = (state_q == RESP) ? data_q : '0;
        mem_req_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
        mem_we        = (state_q == WR_REQ);
        mem_addr      = {ea_q[XLEN-1:LW], {LW{1'b0}}};
        mem_wdata     = '0;
        mem_be        = '0;
        if (state_q == RD_REQ) begin
            mem_be = '1;
        end else if (state_q == WR_REQ) begin
            // A full-word store in RMW mode takes the strobe path; its lane
            // mask and replicated data are then the whole word anyway.
            mem_be    = rmw_q ? {NB{1'b1}} : be_lane;
            mem_wdata = rmw_q ? data_q : wdata_rep;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_ctrl
// Directed bench for lsu_ctrl. Three instances share one stimulus bus:
//   sel 0 : XLEN=32, RMW_STORE=1
//   sel 1 : XLEN=32, RMW_STORE=0
//   sel 2 : XLEN=64, RMW_STORE=1
// Only the selected instance sees req_valid; its outputs are muxed (zero
// extended to 64 bits) onto the o_* signals the transaction task observes.
// ----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [63:0] req_base, req_offset, req_wdata;
    logic        resp_ready;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    // Instance A (32, RMW)
    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_req_valid, a_mem_we, a_busy;
    logic [31:0] a_resp_data, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_be;
    // Instance B (32, strobes)
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_req_valid, b_mem_we, b_busy;
    logic [31:0] b_resp_data, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;
    // Instance C (64, RMW)
    logic        c_req_ready, c_resp_valid, c_resp_err, c_mem_req_valid, c_mem_we, c_busy;
    logic [63:0] c_resp_data, c_mem_addr, c_mem_wdata;
    logic [7:0]  c_mem_be;

    lsu_ctrl #(.XLEN(32), .RMW_STORE(1'b1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel == 0), .req_ready(a_req_ready), .req_op(req_op),
        .req_base(req_base[31:0]), .req_offset(req_offset[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_data(a_resp_data),
        .resp_err(a_resp_err), .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_be(a_mem_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0]), .busy(a_busy)
    );

    lsu_ctrl #(.XLEN(32), .RMW_STORE(1'b0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel == 1), .req_ready(b_req_ready), .req_op(req_op),
        .req_base(req_base[31:0]), .req_offset(req_offset[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_data(b_resp_data),
        .resp_err(b_resp_err), .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0]), .busy(b_busy)
    );

    lsu_ctrl #(.XLEN(64), .RMW_STORE(1'b1)) u_dut_c (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel == 2), .req_ready(c_req_ready), .req_op(req_op),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(c_resp_valid), .resp_ready(resp_ready), .resp_data(c_resp_data),
        .resp_err(c_resp_err), .mem_req_valid(c_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_be(c_mem_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(c_busy)
    );

    // Observed outputs of the selected instance
    logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_req_valid, o_mem_we, o_busy;
    logic [63:0] o_resp_data, o_mem_addr, o_mem_wdata;
    logic [7:0]  o_mem_be;

    always_comb begin
        o_req_ready = c_req_ready;  o_resp_valid = c_resp_valid; o_resp_err = c_resp_err;
        o_mem_req_valid = c_mem_req_valid; o_mem_we = c_mem_we; o_busy = c_busy;
        o_resp_data = c_resp_data; o_mem_addr = c_mem_addr; o_mem_wdata = c_mem_wdata;
        o_mem_be = c_mem_be;
        if (sel == 0) begin
            o_req_ready = a_req_ready;  o_resp_valid = a_resp_valid; o_resp_err = a_resp_err;
            o_mem_req_valid = a_mem_req_valid; o_mem_we = a_mem_we; o_busy = a_busy;
            o_resp_data = {32'd0, a_resp_data}; o_mem_addr = {32'd0, a_mem_addr};
            o_mem_wdata = {32'd0, a_mem_wdata}; o_mem_be = {4'd0, a_mem_be};
        end else if (sel == 1) begin
            o_req_ready = b_req_ready;  o_resp_valid = b_resp_valid; o_resp_err = b_resp_err;
            o_mem_req_valid = b_mem_req_valid; o_mem_we = b_mem_we; o_busy = b_busy;
            o_resp_data = {32'd0, b_resp_data}; o_mem_addr = {32'd0, b_mem_addr};
            o_mem_wdata = {32'd0, b_mem_wdata}; o_mem_be = {4'd0, b_mem_be};
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Results of the last transaction
    logic [63:0] r_data, w_data, m_addr;
    logic [7:0]  w_be;
    logic        r_err;
    int          r_lat, n_rd, n_wr, unstable, rr_bad;
    bit          done;

    // Runs one request through the selected instance. The memory accepts
    // after mhold stalled cycles and returns read data the cycle after a read
    // is accepted; the response is accepted after rhold stalled cycles.
    // r_lat counts clock edges from the accepting edge (inclusive) until
    // resp_valid is seen.
    task automatic txn(input int s, input logic [3:0] op, input logic [63:0] base,
                       input logic [63:0] off, input logic [63:0] wd, input logic [63:0] rd,
                       input int mhold, input int rhold);
        int          mst, rcnt, edges;
        bit          accepted, snap_m, snap_r, hs, acc, rdacc, rhs;
        logic [200:0] msnap;
        sel = s;
        n_rd = 0; n_wr = 0; unstable = 0; rr_bad = 0; done = 0;
        r_data = '0; r_err = 1'b0; r_lat = -1; w_data = '0; w_be = '0; m_addr = '0;
        mst = 0; rcnt = 0; edges = 0; accepted = 0; snap_m = 0; snap_r = 0; msnap = '0;
        @(negedge clk);
        req_op = op; req_base = base; req_offset = off; req_wdata = wd;
        req_valid = 1'b1; mem_rsp_valid = 1'b0; resp_ready = 1'b0; mem_req_ready = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (o_mem_req_valid && mst < mhold) begin
                mem_req_ready = 1'b0;
                mst++;
            end else begin
                mem_req_ready = 1'b1;
            end
            if (o_mem_req_valid) begin
                if (snap_m && msnap != {o_mem_addr, o_mem_we, o_mem_wdata, o_mem_be}) unstable++;
                snap_m = 1;
                msnap  = {o_mem_addr, o_mem_we, o_mem_wdata, o_mem_be};
            end
            if (o_resp_valid) begin
                if (!snap_r) begin
                    snap_r = 1; r_data = o_resp_data; r_err = o_resp_err; r_lat = edges;
                end else if (o_resp_data !== r_data || o_resp_err !== r_err) begin
                    unstable++;
                end
                if (rcnt < rhold) begin
                    rcnt++;
                    resp_ready = 1'b0;
                end else begin
                    resp_ready = 1'b1;
                end
            end else begin
                resp_ready = 1'b0;
            end
            if (accepted && o_req_ready) rr_bad++;
            acc   = o_mem_req_valid && mem_req_ready;
            rdacc = acc && !o_mem_we;
            if (acc) begin
                if (n_rd + n_wr == 0) m_addr = o_mem_addr;
                if (o_mem_we) begin
                    n_wr++; w_data = o_mem_wdata; w_be = o_mem_be;
                end else begin
                    n_rd++;
                end
                snap_m = 0;
            end
            hs  = req_valid && o_req_ready;
            rhs = o_resp_valid && resp_ready;
            @(posedge clk);
            if (accepted) edges++;
            if (hs) begin accepted = 1; edges = 1; end
            if (rhs) done = 1;
            @(negedge clk);
            if (hs) req_valid = 1'b0;
            mem_rsp_valid = rdacc;
            mem_rdata     = rd;
        end
        req_valid = 1'b0; resp_ready = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
        check("completed", 64'(done), 64'd1);
    endtask

    task automatic expect_txn(input string tag, input logic [63:0] data, input logic err,
                              input int lat, input int rd, input int wr);
        check({tag, "_data"}, r_data, data);
        check({tag, "_err"}, 64'(r_err), 64'(err));
        check({tag, "_lat"}, 64'(r_lat), 64'(lat));
        check({tag, "_nrd"}, 64'(n_rd), 64'(rd));
        check({tag, "_nwr"}, 64'(n_wr), 64'(wr));
        check({tag, "_rdy"}, 64'(rr_bad), 64'd0);
        check({tag, "_stable"}, 64'(unstable), 64'd0);
    endtask

    initial begin
        rst = 1'b0; sel = 0; req_valid = 1'b0; req_op = '0; req_base = '0; req_offset = '0;
        req_wdata = '0; resp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(o_req_ready), 64'd1);
        check("rst_outputs", {o_resp_valid, o_resp_err, o_mem_req_valid, o_mem_we, o_busy,
                              o_mem_be, o_resp_data[15:0], o_mem_addr[15:0], o_mem_wdata[15:0]}, 64'd0);
        rst = 1'b1;

        // XLEN=32, RMW stores
        txn(0, 4'b0000, 64'h100, 64'h3, 64'h0, 64'h80AB_CD12, 0, 0);   // LB
        expect_txn("lb", 64'hFFFF_FF80, 1'b0, 3, 1, 0);
        check("lb_addr", m_addr, 64'h100);

        txn(0, 4'b0101, 64'h200, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h9876_5432, 0, 0); // LHU
        expect_txn("lhu", 64'h0000_9876, 1'b0, 3, 1, 0);
        check("lhu_addr", m_addr, 64'h1FC);

        txn(0, 4'b1000, 64'h101, 64'h0, 64'h55, 64'h1122_3344, 0, 0);  // SB, RMW
        expect_txn("sb_rmw", 64'h0, 1'b0, 4, 1, 1);
        check("sb_rmw_wdata", w_data, 64'h1122_5544);
        check("sb_rmw_be", 64'(w_be), 64'hF);

        txn(0, 4'b1010, 64'h10, 64'h4, 64'hCAFE_BABE, 64'h0, 0, 0);   // SW full word
        expect_txn("sw", 64'h0, 1'b0, 2, 0, 1);
        check("sw_wdata", w_data, 64'hCAFE_BABE);
        check("sw_addr", m_addr, 64'h14);

        txn(0, 4'b0010, 64'h102, 64'h0, 64'h0, 64'h0, 0, 0);          // misaligned LW
        expect_txn("lw_mis", 64'h0, 1'b1, 1, 0, 0);
        txn(0, 4'b1011, 64'h100, 64'h0, 64'h1, 64'h0, 0, 0);          // SD on XLEN=32
        expect_txn("sd32", 64'h0, 1'b1, 1, 0, 0);
        txn(0, 4'b1100, 64'h100, 64'h0, 64'h1, 64'h0, 0, 0);          // unsigned store
        expect_txn("sbu", 64'h0, 1'b1, 1, 0, 0);

        txn(0, 4'b0001, 64'h300, 64'h0, 64'h0, 64'h1234_F00D, 5, 3);  // LH, backpressure
        expect_txn("lh_bp", 64'hFFFF_F00D, 1'b0, 8, 1, 0);

        // XLEN=32, strobed stores
        txn(1, 4'b1000, 64'h101, 64'h0, 64'h55, 64'h1122_3344, 0, 0);
        expect_txn("sb_strb", 64'h0, 1'b0, 2, 0, 1);
        check("sb_strb_wdata", w_data, 64'h5555_5555);
        check("sb_strb_be", 64'(w_be), 64'h2);

        txn(1, 4'b1001, 64'h102, 64'h0, 64'hABCD_1234, 64'h0, 5, 3);
        expect_txn("sh_strb_bp", 64'h0, 1'b0, 7, 0, 1);
        check("sh_strb_wdata", w_data, 64'h1234_1234);
        check("sh_strb_be", 64'(w_be), 64'hC);

        // XLEN=64: reset in the middle of RD_WAIT
        sel = 2;
        @(negedge clk);
        req_op = 4'b0011; req_base = 64'h40; req_offset = 64'h0; req_valid = 1'b1;
        mem_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rdwait_busy", {o_busy, o_mem_req_valid, o_resp_valid}, 64'b100);
        rst = 1'b0;
        #1;
        check("midrst_req_ready", 64'(o_req_ready), 64'd1);
        check("midrst_outputs", {o_resp_valid, o_resp_err, o_mem_req_valid, o_mem_we, o_busy,
                                 o_mem_be, o_mem_addr[27:0], o_resp_data[27:0]}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stale_rsp_ignored", {o_resp_valid, o_busy, o_mem_req_valid}, 64'b000);

        txn(2, 4'b0011, 64'h8, 64'h0, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, 0); // LD
        expect_txn("ld64", 64'hDEAD_BEEF_0123_4567, 1'b0, 3, 1, 0);
        check("ld64_addr", m_addr, 64'h8);

        txn(2, 4'b0010, 64'h8, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 0, 0); // LW signed
        expect_txn("lw64", 64'hFFFF_FFFF_8765_4321, 1'b0, 3, 1, 0);
        check("lw64_addr", m_addr, 64'h8);

        txn(2, 4'b1010, 64'h4, 64'h0, 64'h1111_2222_AABB_CCDD, 64'h0102_0304_0506_0708, 0, 0);
        expect_txn("sw64_rmw", 64'h0, 1'b0, 4, 1, 1);
        check("sw64_wdata", w_data, 64'hAABB_CCDD_0506_0708);
        check("sw64_be", 64'(w_be), 64'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
